sc_stream_decoder: RTL and testbench
====================================

// Module: sc_stream_decoder
// PURPOSE
// - Stochastic-to-binary converter: counts 1s in a serial stochastic bitstream over a
//   fixed window of 2**N accepted bits and emits the binary value once per window.
// - Receiving end of the VDC-driven stochastic number generators; sits at the output
//   of the SC FIR datapath.
// - seq_idx tracks the generator's in-window index so the FIR output lines up with the
//   VDC sequence.
// PARAMETERS
// - N       12   log2 of window length; window = 2**N bits
// - RES_W   N+1  result width (N+2 when SC_DEC_BIPOLAR_EN defined); derived, do not override
// PORTS
// - clock      in   1      rising-edge clock; sole clock domain
// - start      in   1      synchronous reset, active-high; clears state, opens a new window
// - bit_in     in   1      stochastic bit
// - bit_valid  in   1      bit_in is valid this cycle
// - in_ready   out  1      decoder can accept bit_in this cycle
// - seq_idx    out  N      index of next bit in current window (0..2**N-1)
// - res_out    out  RES_W  decoded window value
// - res_valid  out  1      res_out holds an untaken result
// - out_ready  in   1      consumer takes res_out when res_valid && out_ready
// BEHAVIOUR
// - Accept: a bit is accepted when bit_valid && in_ready at a rising clock edge.
// - Reset: start=1 at an edge gives, next cycle: seq_idx=0, internal ones count=0,
//   res_out=0, res_valid=0, in_ready=1. start wins over all other inputs, mid-window included.
// - State: ACCUM (seq_idx<2**N-1) and LAST (seq_idx==2**N-1), decoded from seq_idx.
// - On an accepted bit in ACCUM: ones <= ones + bit_in; seq_idx <= seq_idx+1.
// - On an accepted bit in LAST: result <= ones + bit_in; ones <= 0; seq_idx wraps to 0;
//   res_valid <= 1.
// - Latency: res_out/res_valid update the cycle after the final bit is accepted.
// - Back-to-back windows run with no bubble.
// - ones width is N+1; an all-ones window yields 2**N with no overflow.
// - Take: res_valid && out_ready with no completion that edge -> res_valid <= 0 next cycle;
//   res_out holds its last value.
// - Simultaneous take and completion: the new result loads and res_valid stays 1.
//   No result is lost or duplicated.
// - Backpressure: in_ready = !(seq_idx==2**N-1 && res_valid && !out_ready), combinational.
//   Only the final bit of a window stalls while the previous result is untaken.
//   ACCUM bits are never stalled.
// - bit_in is ignored when the bit is not accepted; seq_idx, ones and result do not change.
// - All outputs are registered except in_ready.
// CONFIGURATION
// - Macro SC_DEC_BIPOLAR_EN.
// - Defined: bipolar encoding. RES_W=N+2; res_out is signed two's complement
//   = 2*ones - 2**N, range -2**N..+2**N.
// - Undefined: unipolar encoding. RES_W=N+1; res_out is unsigned = ones, range 0..2**N.
// - Handshake, timing and seq_idx are identical in both builds.
// TESTING
// - N=2, start, then bits 1,0,1,1 valid every cycle, out_ready=1
//   -> res_out=3 (bipolar: +2), res_valid high the cycle after the 4th bit, then low.
// - N=12, 4096 ones then 4096 zeros, valid every cycle
//   -> results 4096 then 0 (bipolar: +4096 then -4096), no bubble between windows.
// - N=2, bit_valid toggled 1,0,0,1,1,0,1 with bits 1,x,x,0,1,x,1
//   -> only valid bits counted, res_out=3, seq_idx advances only on accept.
// - N=2, out_ready=0, two full windows of 1s
//   -> in_ready=0 at seq_idx=3 of window 2 and res_out stays 4.
//   Raise out_ready one cycle -> final bit accepted, res_out=4 again, res_valid stays 1.
// - N=2, start asserted at seq_idx=2 with ones=2 -> next cycle seq_idx=0, res_valid=0;
//   window 0,0,1,0 then -> res_out=1.
// - N=2, out_ready=1 on the same edge as the final bit of the next window
//   -> res_valid stays 1, res_out switches to the new value, exactly one take per result.

Source files
------------

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder
//   Stochastic-to-binary converter. Counts the 1s of a serial stochastic
//   bitstream over a window of 2**N accepted bits and emits one binary value
//   per window. seq_idx follows the generator's in-window index so the FIR
//   output lines up with the VDC sequence.
//
//   Build option: define SC_DEC_BIPOLAR_EN for bipolar encoding
//   (res_out = 2*ones - 2**N, signed, RES_W = N+2). Without it the result is
//   unipolar (res_out = ones, unsigned, RES_W = N+1). Handshake and timing
//   are the same in both builds.
//
// Ports
//   clock      in   1      rising-edge clock
//   start      in   1      synchronous active-high reset, opens a new window
//   bit_in     in   1      stochastic bit
//   bit_valid  in   1      bit_in valid this cycle
//   in_ready   out  1      decoder accepts bit_in this cycle (combinational)
//   seq_idx    out  N      index of the next bit in the current window
//   res_out    out  RES_W  decoded window value
//   res_valid  out  1      res_out holds an untaken result
//   out_ready  in   1      consumer takes res_out when res_valid && out_ready
//
// state | meaning
// ------+-----------------------------------------------------------
// ACCUM | seq_idx < 2**N-1, accepted bits add into the ones count
// LAST  | seq_idx == 2**N-1, next accepted bit completes the window

module sc_stream_decoder #(
  parameter int N = 12,
`ifdef SC_DEC_BIPOLAR_EN
  localparam int RES_W = N + 2
`else
  localparam int RES_W = N + 1
`endif
) (
  input  logic             clock,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             in_ready,
  output logic [N-1:0]     seq_idx,
  output logic [RES_W-1:0] res_out,
  output logic             res_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, LAST} state_t;

  state_t           state;
  logic [N:0]       ones;
  logic [N:0]       ones_next;
  logic [N:0]       sum;
  logic [N-1:0]     seq_idx_next;
  logic [RES_W-1:0] res_next;
  logic [RES_W-1:0] res_enc;
  logic             res_valid_next;
  logic             accept;

  // The window position is the only state; ACCUM/LAST is decoded from it.
  assign state = (seq_idx == '1) ? LAST : ACCUM;

  // Only the closing bit can stall, and only while the previous result is
  // still waiting for the consumer.
  assign in_ready = !(state == LAST && res_valid && !out_ready);
  assign accept   = bit_valid && in_ready;

  // N+1 bits: an all-ones window reaches exactly 2**N.
  assign sum = ones + {{N{1'b0}}, bit_in};

`ifdef SC_DEC_BIPOLAR_EN
  assign res_enc = {sum, 1'b0} - (RES_W'(1) << N);
`else
  assign res_enc = sum;
`endif

  always_comb begin
    ones_next      = ones;
    seq_idx_next   = seq_idx;
    res_next       = res_out;
    res_valid_next = res_valid;

    if (res_valid && out_ready) res_valid_next = 1'b0;

    if (accept) begin
      case (state)
        ACCUM: begin
          ones_next    = sum;
          seq_idx_next = seq_idx + N'(1);
        end
        LAST: begin
          // A completion in the same cycle as a take overrides the clear,
          // so the new result is presented without a gap.
          res_next       = res_enc;
          ones_next      = '0;
          seq_idx_next   = '0;
          res_valid_next = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      ones      <= '0;
      seq_idx   <= '0;
      res_out   <= '0;
      res_valid <= 1'b0;
    end else begin
      ones      <= ones_next;
      seq_idx   <= seq_idx_next;
      res_out   <= res_next;
      res_valid <= res_valid_next;
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
module tb_sc_stream_decoder;
  localparam int N   = 2;
  localparam int W   = 1 << N;
  localparam int N12 = 12;
  localparam int W12 = 1 << N12;
`ifdef SC_DEC_BIPOLAR_EN
  localparam int RW   = N + 2;
  localparam int RW12 = N12 + 2;
`else
  localparam int RW   = N + 1;
  localparam int RW12 = N12 + 1;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          start = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, res_valid;
  logic [N-1:0]  seq_idx;
  logic [RW-1:0] res_out;

  logic            s12 = 1'b1, bi12 = 1'b0, bv12 = 1'b0, or12 = 1'b1;
  logic            rdy12, rv12;
  logic [N12-1:0]  idx12;
  logic [RW12-1:0] ro12;

  sc_stream_decoder #(.N(N)) dut (
    .clock(clock), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .in_ready(in_ready), .seq_idx(seq_idx), .res_out(res_out),
    .res_valid(res_valid), .out_ready(out_ready)
  );

  sc_stream_decoder #(.N(N12)) dut12 (
    .clock(clock), .start(s12), .bit_in(bi12), .bit_valid(bv12),
    .in_ready(rdy12), .seq_idx(idx12), .res_out(ro12),
    .res_valid(rv12), .out_ready(or12)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the bits accepted so far in the open window, plus the
  // result currently offered to the consumer.
  bit   q_win[$];
  int   m_res   = 0;
  bit   m_valid = 1'b0;
  bit   exp_rdy;
  logic obs_rdy;

  function automatic int enc(input int ones, input int w);
`ifdef SC_DEC_BIPOLAR_EN
    return 2 * ones - w;
`else
    return ones;
`endif
  endfunction

  // One clock on the N=2 decoder: drive, sample in_ready before the edge,
  // advance the model at the edge, return at the following negedge.
  task automatic tick(input logic st, input logic bv, input logic bi, input logic ory);
    int ones;
    bit took;
    bit done;
    start = st; bit_valid = bv; bit_in = bi; out_ready = ory;
    #1;
    exp_rdy = !(q_win.size() == W - 1 && m_valid && !ory);
    obs_rdy = in_ready;
    @(posedge clock);
    if (st) begin
      q_win.delete(); m_res = 0; m_valid = 1'b0;
    end else begin
      took = m_valid && ory;
      done = 1'b0;
      if (bv && exp_rdy) begin
        q_win.push_back(bi);
        if (q_win.size() == W) begin
          ones = 0;
          foreach (q_win[i]) ones += int'(q_win[i]);
          m_res = enc(ones, W); m_valid = 1'b1; done = 1'b1;
          q_win.delete();
        end
      end
      if (took && !done) m_valid = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (seq_idx !== '0) begin failures++; $display("FAIL reset_seq_idx got=%0d exp=0", seq_idx); end
    checks++; if (res_out !== '0) begin failures++; $display("FAIL reset_res_out got=%0h exp=0", res_out); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    logic b[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   e_idx;
    int   ev;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, b[i], 1'b1);
      e_idx = q_win.size();
      checks++; if (seq_idx !== e_idx[N-1:0]) begin failures++; $display("FAIL basic_seq_idx[%0d] got=%0d exp=%0d", i, seq_idx, e_idx); end
    end
    ev = enc(3, W);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL basic_res_valid got=%b exp=1", res_valid); end
    checks++; if (res_out !== ev[RW-1:0]) begin failures++; $display("FAIL basic_res_out got=%0h exp=%0h", res_out, ev[RW-1:0]); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_taken got=%b exp=0", res_valid); end
    checks++; if (res_out !== ev[RW-1:0]) begin failures++; $display("FAIL basic_hold got=%0h exp=%0h", res_out, ev[RW-1:0]); end
  endtask

  task automatic test_gaps();
    logic v[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic b[7];
    int   e_idx;
    int   ev;
    b = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    b[1] = 1'($urandom_range(0, 1)); b[2] = 1'b1; b[5] = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, v[i], b[i], 1'b1);
      e_idx = q_win.size();
      checks++; if (seq_idx !== e_idx[N-1:0]) begin failures++; $display("FAIL gaps_seq_idx[%0d] got=%0d exp=%0d", i, seq_idx, e_idx); end
    end
    ev = enc(3, W);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL gaps_res_valid got=%b exp=1", res_valid); end
    checks++; if (res_out !== ev[RW-1:0]) begin failures++; $display("FAIL gaps_res_out got=%0h exp=%0h", res_out, ev[RW-1:0]); end
  endtask

  task automatic test_backpressure();
    int ev;
    ev = enc(4, W);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (seq_idx !== 2'd3) begin failures++; $display("FAIL bp_seq_idx got=%0d exp=3", seq_idx); end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL bp_stall_in_ready got=%b exp=0", obs_rdy); end
    checks++; if (seq_idx !== 2'd3) begin failures++; $display("FAIL bp_stall_seq_idx got=%0d exp=3", seq_idx); end
    checks++; if (res_out !== ev[RW-1:0]) begin failures++; $display("FAIL bp_stall_res_out got=%0h exp=%0h", res_out, ev[RW-1:0]); end
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", obs_rdy); end
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_release_res_valid got=%b exp=1", res_valid); end
    checks++; if (res_out !== ev[RW-1:0]) begin failures++; $display("FAIL bp_release_res_out got=%0h exp=%0h", res_out, ev[RW-1:0]); end
    checks++; if (seq_idx !== 2'd0) begin failures++; $display("FAIL bp_release_seq_idx got=%0d exp=0", seq_idx); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_final_take got=%b exp=0", res_valid); end
  endtask

  task automatic test_midwindow_start();
    logic b[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int   ev;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (seq_idx !== 2'd0) begin failures++; $display("FAIL mid_start_seq_idx got=%0d exp=0", seq_idx); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_start_res_valid got=%b exp=0", res_valid); end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, b[i], 1'b1);
    ev = enc(1, W);
    checks++; if (res_out !== ev[RW-1:0]) begin failures++; $display("FAIL mid_start_res_out got=%0h exp=%0h", res_out, ev[RW-1:0]); end
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL mid_start_valid got=%b exp=1", res_valid); end
  endtask

  task automatic test_back_to_back();
    logic b1[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic b2[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   ev;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, b1[i], 1'b0);
    ev = enc(2, W);
    checks++; if (res_out !== ev[RW-1:0]) begin failures++; $display("FAIL b2b_first got=%0h exp=%0h", res_out, ev[RW-1:0]); end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, b2[i], 1'b0);
    tick(1'b0, 1'b1, b2[3], 1'b1);
    ev = enc(3, W);
    checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", obs_rdy); end
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL b2b_res_valid got=%b exp=1", res_valid); end
    checks++; if (res_out !== ev[RW-1:0]) begin failures++; $display("FAIL b2b_second got=%0h exp=%0h", res_out, ev[RW-1:0]); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_single_take got=%b exp=0", res_valid); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_dup got=%b exp=0", res_valid); end
  endtask

  task automatic test_random();
    int e_idx;
    int e_res;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      tick(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      e_idx = q_win.size();
      e_res = m_res;
      checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", c, obs_rdy, exp_rdy); end
      checks++; if (seq_idx !== e_idx[N-1:0]) begin failures++; $display("FAIL rand_seq_idx[%0d] got=%0d exp=%0d", c, seq_idx, e_idx); end
      checks++; if (res_valid !== m_valid) begin failures++; $display("FAIL rand_res_valid[%0d] got=%b exp=%b", c, res_valid, m_valid); end
      checks++; if (res_out !== e_res[RW-1:0]) begin failures++; $display("FAIL rand_res_out[%0d] got=%0h exp=%0h", c, res_out, e_res[RW-1:0]); end
    end
  endtask

  task automatic test_n12_windows();
    bit stalled;
    int ev;
    stalled = 1'b0;
    s12 = 1'b1; bv12 = 1'b0; or12 = 1'b1;
    @(posedge clock); @(negedge clock);
    s12 = 1'b0;
    for (int i = 0; i < 2 * W12; i++) begin
      bv12 = 1'b1; bi12 = (i < W12); or12 = 1'b1;
      #1;
      if (rdy12 !== 1'b1) stalled = 1'b1;
      @(posedge clock); @(negedge clock);
      if (i == W12 - 1) begin
        ev = enc(W12, W12);
        checks++; if (rv12 !== 1'b1) begin failures++; $display("FAIL n12_first_valid got=%b exp=1", rv12); end
        checks++; if (ro12 !== ev[RW12-1:0]) begin failures++; $display("FAIL n12_all_ones got=%0h exp=%0h", ro12, ev[RW12-1:0]); end
        checks++; if (idx12 !== '0) begin failures++; $display("FAIL n12_wrap got=%0d exp=0", idx12); end
      end
      if (i == W12) begin
        checks++; if (idx12 !== 12'd1) begin failures++; $display("FAIL n12_no_bubble got=%0d exp=1", idx12); end
      end
    end
    ev = enc(0, W12);
    checks++; if (rv12 !== 1'b1) begin failures++; $display("FAIL n12_second_valid got=%b exp=1", rv12); end
    checks++; if (ro12 !== ev[RW12-1:0]) begin failures++; $display("FAIL n12_all_zeros got=%0h exp=%0h", ro12, ev[RW12-1:0]); end
    checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL n12_in_ready_stall got=%b exp=0", stalled); end
    bv12 = 1'b0; s12 = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_midwindow_start();
    test_back_to_back();
    test_random();
    test_n12_windows();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
